clk_div_multi: RTL

- Parametrised multi-channel clock divider; next generation of the fixed two-output divider.
- NUM_CH independent channels; each has a runtime-programmable integer divisor, an enable and a single-cycle tick strobe.
- Divisor updates are glitch-free and applied only at a period boundary. A global sync re-aligns the phases of all channels.
- Feeds FIFO write/read clock-enable generation and other rate-derived logic.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 75 +++++++
 rtl/clk_div_multi.sv | 37 +++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV   = 2;
  localparam int DEF_CNT_W = 8;

  // Divisors below MIN_DIV cannot produce a clock with both phases present.
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < 32'(MIN_DIV)) ? 32'(MIN_DIV) : value;
  endfunction

  // Odd divisors give the extra cycle to the high phase.
  function automatic logic [31:0] high_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor, clk_out and tick flops.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ch_en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  localparam logic [CNT_W-1:0] RESET_N = CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_act;
  logic [CNT_W-1:0] n_pend;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] next_div;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_n;
  logic             wrap;

  always_comb begin
    load_val = CNT_W'(clamp_div(32'(div_value)));
    // A load on the same edge as a wrap takes effect at that wrap.
    next_div = div_load ? load_val : n_pend;
    cnt_inc  = cnt + 1'b1;
    high_n   = CNT_W'(high_len(32'(n_act)));
    wrap     = sync || (cnt == n_act - 1'b1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= RESET_N - 1'b1;
      n_act   <= RESET_N;
      n_pend  <= RESET_N;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (!ch_en) begin
      // Parked at end-of-period so re-enabling rises on the very next edge.
      cnt     <= next_div - 1'b1;
      n_act   <= next_div;
      n_pend  <= next_div;
      pend    <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else if (wrap) begin
      cnt     <= '0;
      n_act   <= next_div;
      n_pend  <= next_div;
      pend    <= 1'b0;
      clk_out <= 1'b1;
      tick    <= 1'b1;
    end else begin
      cnt     <= cnt_inc;
      clk_out <= (cnt_inc < high_n);
      tick    <= 1'b0;
      if (div_load) begin
        n_pend <= load_val;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider; replicates clk_div_chan per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int RESET_DIV = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*CNT_W-1:0] div_value,
  input  logic                    sync,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pend
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .ch_en     (ch_en[i]),
      .div_load  (div_load[i]),
      .div_value (div_value[i*CNT_W +: CNT_W]),
      .sync      (sync),
      .clk_out   (clk_out[i]),
      .tick      (tick[i]),
      .pend      (pend[i])
    );
  end

endmodule
